// File: rtl/amo_lrsc_shim.sv
// -----------------------------------------------------------------------------
// amo_lrsc_shim
//
// Atomic shim in front of a single-port SRAM bank with 1-cycle read latency.
// The shim owns the bank exclusively. Plain loads/stores feed straight
// through. AMOs (Swap..CAS) run as read-modify-write: the grant cycle reads
// the bank, and the following AmoWrite cycle writes the ALU result back while
// new requests are held off. LR/SC use one reservation slot per master; any
// bank write kills every reservation on the written address.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   in_req_i / in_gnt_o        request / grant handshake
//   in_add_i                   word address
//   in_amo_i                   0 none, 1 swap, 2 add, 3 and, 4 or, 5 xor,
//                              6 max, 7 maxu, 8 min, 9 minu, A cas, B lr, C sc
//   in_wen_i                   1 store, 0 load (plain accesses only)
//   in_wdata_i, in_be_i        write data / AMO operand, byte enables
//   in_id_i                    master ID
//   in_rdata_o, in_rvalid_o,
//   in_rid_o                   response, one cycle after each grant
//   out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o
//                              bank request side
//   out_rdata_i                bank read data, valid one cycle after a read
// -----------------------------------------------------------------------------
module amo_lrsc_shim #(
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned NumMasters   = 8,
    parameter int unsigned IdWidth      = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_req_i,
    output logic                    in_gnt_o,
    input  logic [AddrMemWidth-1:0] in_add_i,
    input  logic [3:0]              in_amo_i,
    input  logic                    in_wen_i,
    input  logic [DataWidth-1:0]    in_wdata_i,
    input  logic [DataWidth/8-1:0]  in_be_i,
    input  logic [IdWidth-1:0]      in_id_i,
    output logic [DataWidth-1:0]    in_rdata_o,
    output logic                    in_rvalid_o,
    output logic [IdWidth-1:0]      in_rid_o,
    output logic                    out_req_o,
    output logic [AddrMemWidth-1:0] out_add_o,
    output logic                    out_wen_o,
    output logic [DataWidth-1:0]    out_wdata_o,
    output logic [DataWidth/8-1:0]  out_be_o,
    input  logic [DataWidth-1:0]    out_rdata_i
);

    localparam int unsigned BeWidth = DataWidth / 8;

    typedef enum logic [3:0] {
        AMO_NONE = 4'h0, AMO_SWAP = 4'h1, AMO_ADD  = 4'h2, AMO_AND  = 4'h3,
        AMO_OR   = 4'h4, AMO_XOR  = 4'h5, AMO_MAX  = 4'h6, AMO_MAXU = 4'h7,
        AMO_MIN  = 4'h8, AMO_MINU = 4'h9, AMO_CAS  = 4'hA, AMO_LR   = 4'hB,
        AMO_SC   = 4'hC
    } amo_op_e;

    typedef enum logic {
        Idle,
        AmoWrite
    } state_e;

    state_e  state_q, state_d;

    // Latched AMO context, used during the write-back cycle.
    amo_op_e                 op_q;
    logic [AddrMemWidth-1:0] addr_q;
    logic                    upper_q;
    logic [31:0]             b_q, cmp_q, swap_q;

    // Response bookkeeping.
    logic               rvalid_q;
    logic [IdWidth-1:0] rid_q;
    logic               sc_resp_q, sc_fail_q;

    // Reservations: one slot per master.
    logic [NumMasters-1:0]   resv_valid_q, resv_valid_d;
    logic [AddrMemWidth-1:0] resv_addr_q [NumMasters];

    // Request decode.
    logic is_amo, is_lr, is_sc, is_plain, id_ok, fire, sc_success, bank_write;

    assign is_amo   = (in_amo_i >= 4'(AMO_SWAP)) && (in_amo_i <= 4'(AMO_CAS));
    assign is_lr    = (in_amo_i == 4'(AMO_LR));
    assign is_sc    = (in_amo_i == 4'(AMO_SC));
    assign is_plain = !is_amo && !is_lr && !is_sc;
    assign id_ok    = (32'(in_id_i) < NumMasters);
    assign fire     = (state_q == Idle) && in_req_i;

    assign sc_success = is_sc && id_ok && resv_valid_q[in_id_i]
                        && (resv_addr_q[in_id_i] == in_add_i);

    // Word selection between the request, the bank and the 32-bit ALU.
    logic               upper_sel;
    logic [31:0]        wdata_word, cmp_word, swap_word, a_word, result;
    logic [BeWidth-1:0] amo_be;
    logic [DataWidth-1:0] amo_wdata, amo_rdata;

    if (DataWidth == 64) begin : g_dw64
        assign upper_sel  = in_be_i[4];
        assign wdata_word = upper_sel ? in_wdata_i[63:32] : in_wdata_i[31:0];
        assign cmp_word   = in_wdata_i[31:0];
        assign swap_word  = in_wdata_i[63:32];
        assign a_word     = upper_q ? out_rdata_i[63:32] : out_rdata_i[31:0];
        assign amo_be     = upper_q ? 8'hF0 : 8'h0F;
        assign amo_wdata  = upper_q ? {result, 32'h0} : {32'h0, result};
        assign amo_rdata  = upper_q ? {a_word, 32'h0} : {32'h0, a_word};
    end else if (DataWidth == 32) begin : g_dw32
        assign upper_sel  = 1'b0;
        assign wdata_word = in_wdata_i;
        assign cmp_word   = '0;
        assign swap_word  = '0;
        assign a_word     = out_rdata_i;
        assign amo_be     = 4'hF;
        assign amo_wdata  = result;
        assign amo_rdata  = a_word;
    end else begin : g_bad_width
        $fatal(1, "amo_lrsc_shim: DataWidth must be 32 or 64");
    end

    // A single 33-bit subtract serves every compare: the extra top bit is the
    // sign copy for signed ops and zero for unsigned ones, so bit 32 is a<b.
    logic        cmp_signed, a_lt_b;
    logic [32:0] diff;

    assign cmp_signed = (op_q == AMO_MAX) || (op_q == AMO_MIN);
    assign diff       = {cmp_signed & a_word[31], a_word} - {cmp_signed & b_q[31], b_q};
    assign a_lt_b     = diff[32];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value held (no latch).
    always_comb begin
        result = a_word;
        unique case (op_q)
            AMO_SWAP:            result = b_q;
            AMO_ADD:             result = a_word + b_q;
            AMO_AND:             result = a_word & b_q;
            AMO_OR:              result = a_word | b_q;
            AMO_XOR:             result = a_word ^ b_q;
            AMO_MAX, AMO_MAXU:   result = a_word_lt_sel(1'b1);
            AMO_MIN, AMO_MINU:   result = a_word_lt_sel(1'b0);
            // The write is issued even on a compare miss; it rewrites the old value.
            AMO_CAS:             result = (DataWidth == 64 && a_word == cmp_q) ? swap_q : a_word;
            default:             result = a_word;
        endcase
    end

    function automatic logic [31:0] a_word_lt_sel(input logic pick_max);
        if (pick_max) return a_lt_b ? b_q : a_word;
        else          return a_lt_b ? a_word : b_q;
    endfunction

    // Next state and bank/grant outputs.
    always_comb begin
        state_d     = state_q;
        in_gnt_o    = 1'b0;
        out_req_o   = 1'b0;
        out_add_o   = in_add_i;
        out_wen_o   = 1'b0;
        out_wdata_o = in_wdata_i;
        out_be_o    = in_be_i;
        unique case (state_q)
            Idle: begin
                in_gnt_o  = in_req_i;
                // A failing SC never reaches the bank.
                out_req_o = in_req_i && !(is_sc && !sc_success);
                out_wen_o = is_sc || (is_plain && in_wen_i);
                if (in_req_i && is_amo) state_d = AmoWrite;
            end
            AmoWrite: begin
                out_req_o   = 1'b1;
                out_wen_o   = 1'b1;
                out_add_o   = addr_q;
                out_wdata_o = amo_wdata;
                out_be_o    = amo_be;
                state_d     = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    assign bank_write = out_req_o && out_wen_o;

    // Reservation update: writes invalidate matching slots first, then the
    // requesting master's own LR sets or SC clears its slot.
    always_comb begin
        resv_valid_d = resv_valid_q;
        if (bank_write) begin
            for (int unsigned i = 0; i < NumMasters; i++) begin
                if (resv_addr_q[i] == out_add_o) resv_valid_d[i] = 1'b0;
            end
        end
        if (fire && id_ok) begin
            if (is_sc) resv_valid_d[in_id_i] = 1'b0;
            if (is_lr) resv_valid_d[in_id_i] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= Idle;
            resv_valid_q <= '0;
            rvalid_q     <= 1'b0;
            rid_q        <= '0;
            sc_resp_q    <= 1'b0;
            sc_fail_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            resv_valid_q <= resv_valid_d;
            rvalid_q     <= fire;
            if (fire) begin
                rid_q     <= in_id_i;
                sc_resp_q <= is_sc;
                sc_fail_q <= !sc_success;
            end
        end
    end

    // NOTE: reservation addresses and AMO operands carry no reset; they are
    // only ever read when qualified by a reset valid bit or by state_q.
    always_ff @(posedge clk_i) begin
        if (fire && is_amo) begin
            op_q    <= amo_op_e'(in_amo_i);
            addr_q  <= in_add_i;
            upper_q <= upper_sel;
            b_q     <= wdata_word;
            cmp_q   <= cmp_word;
            swap_q  <= swap_word;
        end
        if (fire && is_lr && id_ok) resv_addr_q[in_id_i] <= in_add_i;
    end

    // CAS needs a 64-bit operand to carry both compare and swap values.
    always_ff @(posedge clk_i) begin
        if (DataWidth == 32 && state_q == AmoWrite && op_q == AMO_CAS) begin
            $error("amo_lrsc_shim: CAS is not supported with DataWidth=32");
        end
    end

    // Responses: AMOs return the old word in its half, SC returns its status
    // flag, everything else returns the bank data.
    always_comb begin
        if (state_q == AmoWrite) in_rdata_o = amo_rdata;
        else if (sc_resp_q)      in_rdata_o = {{(DataWidth-1){1'b0}}, sc_fail_q};
        else                     in_rdata_o = out_rdata_i;
    end

    assign in_rvalid_o = rvalid_q;
    assign in_rid_o    = rid_q;

endmodule

// File: tb/tb_amo_lrsc_shim.sv
module tb_amo_lrsc_shim;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_req_i;
    logic        in_gnt_o;
    logic [31:0] in_add_i;
    logic [3:0]  in_amo_i;
    logic        in_wen_i;
    logic [63:0] in_wdata_i;
    logic [7:0]  in_be_i;
    logic [2:0]  in_id_i;
    logic [63:0] in_rdata_o;
    logic        in_rvalid_o;
    logic [2:0]  in_rid_o;
    logic        out_req_o;
    logic [31:0] out_add_o;
    logic        out_wen_o;
    logic [63:0] out_wdata_o;
    logic [7:0]  out_be_o;
    logic [63:0] out_rdata_i;

    amo_lrsc_shim dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
        .in_amo_i(in_amo_i), .in_wen_i(in_wen_i), .in_wdata_i(in_wdata_i),
        .in_be_i(in_be_i), .in_id_i(in_id_i), .in_rdata_o(in_rdata_o),
        .in_rvalid_o(in_rvalid_o), .in_rid_o(in_rid_o),
        .out_req_o(out_req_o), .out_add_o(out_add_o), .out_wen_o(out_wen_o),
        .out_wdata_o(out_wdata_o), .out_be_o(out_be_o), .out_rdata_i(out_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Bank: single-port SRAM, 1-cycle read latency, byte-enabled writes.
    logic [63:0] bank_mem [256];
    always @(posedge clk_i) begin
        if (out_req_o) begin
            if (out_wen_o) begin
                for (int i = 0; i < 8; i++)
                    if (out_be_o[i]) bank_mem[out_add_o[7:0]][i*8 +: 8] <= out_wdata_o[i*8 +: 8];
            end else begin
                out_rdata_i <= bank_mem[out_add_o[7:0]];
            end
        end
    end

    typedef struct {
        string       name;
        logic [3:0]  amo;
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [2:0]  id;
        logic [63:0] exp_rdata;
        bit          chk_data;
        int          exp_stall;
        bit          exp_breq;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] amo, input logic wen,
                                input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] be,
                                input logic [2:0] id, input logic [63:0] exp, input bit chk,
                                input int stall, input bit breq);
        vec_t v;
        v.name = n; v.amo = amo; v.wen = wen; v.addr = addr; v.wdata = wd; v.be = be;
        v.id = id; v.exp_rdata = exp; v.chk_data = chk; v.exp_stall = stall; v.exp_breq = breq;
        return v;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    logic [63:0] ref_mem     [256];
    bit          ref_written [256];
    bit          rsv_valid   [8];
    logic [31:0] rsv_addr    [8];
    bit          last_amo = 1'b0;

    task automatic mem_write(input logic [31:0] addr, input logic [63:0] d, input logic [7:0] be);
        for (int i = 0; i < 8; i++)
            if (be[i]) ref_mem[addr[7:0]][i*8 +: 8] = d[i*8 +: 8];
        ref_written[addr[7:0]] = 1'b1;
        for (int m = 0; m < 8; m++)
            if (rsv_valid[m] && rsv_addr[m] == addr) rsv_valid[m] = 1'b0;
    endtask

    task automatic model(input vec_t v, output vec_t e);
        logic [63:0] old;
        logic [31:0] a, b, r;
        bit up, ok;
        e = v;
        e.exp_stall = last_amo ? 1 : 0;
        e.exp_breq  = 1'b1;
        e.chk_data  = 1'b1;
        old = ref_mem[v.addr[7:0]];
        up  = v.be[4];
        a   = up ? old[63:32] : old[31:0];
        b   = up ? v.wdata[63:32] : v.wdata[31:0];
        last_amo = 1'b0;
        if (v.amo == 4'hB) begin
            e.exp_rdata = old;
            rsv_valid[v.id] = 1'b1;
            rsv_addr[v.id]  = v.addr;
        end else if (v.amo == 4'hC) begin
            ok = rsv_valid[v.id] && rsv_addr[v.id] == v.addr;
            rsv_valid[v.id] = 1'b0;
            if (ok) mem_write(v.addr, v.wdata, v.be);
            e.exp_rdata = ok ? 64'd0 : 64'd1;
            e.exp_breq  = ok;
        end else if (v.amo >= 4'h1 && v.amo <= 4'hA) begin
            case (v.amo)
                4'h1:    r = b;
                4'h2:    r = a + b;
                4'h3:    r = a & b;
                4'h4:    r = a | b;
                4'h5:    r = a ^ b;
                4'h6:    r = ($signed(a) > $signed(b)) ? a : b;
                4'h7:    r = (a > b) ? a : b;
                4'h8:    r = ($signed(a) < $signed(b)) ? a : b;
                4'h9:    r = (a < b) ? a : b;
                default: r = (a == v.wdata[31:0]) ? v.wdata[63:32] : a;
            endcase
            mem_write(v.addr, up ? {r, 32'h0} : {32'h0, r}, up ? 8'hF0 : 8'h0F);
            e.exp_rdata = up ? {a, 32'h0} : {32'h0, a};
            last_amo = 1'b1;
        end else if (v.wen) begin
            mem_write(v.addr, v.wdata, v.be);
            e.chk_data = 1'b0;
        end else begin
            e.exp_rdata = old;
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; returns just after the falling edge
    // at which the response is visible.
    task automatic issue(input vec_t v, output logic [63:0] rd, output logic [2:0] rid,
                         output logic rv, output int stalls, output logic breq);
        in_req_i = 1'b1; in_amo_i = v.amo; in_wen_i = v.wen; in_add_i = v.addr;
        in_wdata_i = v.wdata; in_be_i = v.be; in_id_i = v.id;
        stalls = 0;
        #1;
        while (!in_gnt_o && stalls < 8) begin
            @(negedge clk_i); #1;
            stalls++;
        end
        if (!in_gnt_o) check({v.name, "/grant_timeout"}, 64'(in_gnt_o), 64'd1);
        breq = out_req_o;
        @(posedge clk_i);
        @(negedge clk_i);
        in_req_i = 1'b0;
        rv  = in_rvalid_o;
        rd  = in_rdata_o;
        rid = in_rid_o;
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] rd;
        logic [2:0]  rid;
        logic        rv, breq;
        int          st;
        issue(v, rd, rid, rv, st, breq);
        check({v.name, "/rvalid"}, 64'(rv), 64'd1);
        check({v.name, "/rid"}, 64'(rid), 64'(v.id));
        check({v.name, "/stall"}, 64'(st), 64'(v.exp_stall));
        check({v.name, "/bank_req"}, 64'(breq), 64'(v.exp_breq));
        if (v.chk_data) check({v.name, "/rdata"}, rd, v.exp_rdata);
    endtask

    task automatic run_model(input vec_t v);
        vec_t e;
        model(v, e);
        run_vec(e);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t e, v;
        logic [63:0] rd;
        logic [2:0]  rid;
        logic        rv, breq;
        int          st;

        for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_written[i] = 1'b0; end
        for (int m = 0; m < 8; m++) rsv_valid[m] = 1'b0;

        // Directed vectors with expectations written from the rules by hand.
        vecs.push_back(mk("st_10",   4'h0, 1, 'h10, 64'h00000005_00000007, 'hFF, 5, 0, 0, 0, 1));
        vecs.push_back(mk("st_11",   4'h0, 1, 'h11, 64'h00000000_FFFFFFFF, 'hFF, 6, 0, 0, 0, 1));
        vecs.push_back(mk("st_12",   4'h0, 1, 'h12, 64'h00000000_80000000, 'hFF, 7, 0, 0, 0, 1));
        vecs.push_back(mk("st_13",   4'h0, 1, 'h13, 64'h7,                 'hFF, 5, 0, 0, 0, 1));
        vecs.push_back(mk("st_14",   4'h0, 1, 'h14, 64'h00000000_FFFFFFFF, 'hFF, 6, 0, 0, 0, 1));
        vecs.push_back(mk("st_20",   4'h0, 1, 'h20, 64'h11111111_11111111, 'hFF, 7, 0, 0, 0, 1));
        vecs.push_back(mk("st_30",   4'h0, 1, 'h30, 64'h0,                 'hFF, 5, 0, 0, 0, 1));
        vecs.push_back(mk("add",     4'h2, 0, 'h10, 64'h3,   'h0F, 1, 64'h00000000_00000007, 1, 0, 1));
        vecs.push_back(mk("ld_10",   4'h0, 0, 'h10, 64'h0,   'hFF, 2, 64'h00000005_0000000A, 1, 1, 1));
        vecs.push_back(mk("max",     4'h6, 0, 'h11, 64'h1,   'h0F, 3, 64'h00000000_FFFFFFFF, 1, 0, 1));
        vecs.push_back(mk("ld_11",   4'h0, 0, 'h11, 64'h0,   'hFF, 4, 64'h00000000_00000001, 1, 1, 1));
        vecs.push_back(mk("maxu",    4'h7, 0, 'h14, 64'h1,   'h0F, 0, 64'h00000000_FFFFFFFF, 1, 0, 1));
        vecs.push_back(mk("ld_14",   4'h0, 0, 'h14, 64'h0,   'hFF, 1, 64'h00000000_FFFFFFFF, 1, 1, 1));
        vecs.push_back(mk("min",     4'h8, 0, 'h12, 64'h0,   'h0F, 1, 64'h00000000_80000000, 1, 0, 1));
        vecs.push_back(mk("ld_12",   4'h0, 0, 'h12, 64'h0,   'hFF, 2, 64'h00000000_80000000, 1, 1, 1));
        vecs.push_back(mk("cas_hit", 4'hA, 0, 'h13, 64'h00000009_00000007, 'h0F, 2, 64'h7, 1, 0, 1));
        vecs.push_back(mk("cas_miss",4'hA, 0, 'h13, 64'h0000000C_00000008, 'h0F, 3, 64'h9, 1, 1, 1));
        vecs.push_back(mk("ld_13",   4'h0, 0, 'h13, 64'h0,   'hFF, 4, 64'h9, 1, 1, 1));
        vecs.push_back(mk("xor_up",  4'h5, 0, 'h10, 64'h0000000F_00000000, 'hF0, 4, 64'h00000005_00000000, 1, 0, 1));
        vecs.push_back(mk("ld_10b",  4'h0, 0, 'h10, 64'h0,   'hFF, 5, 64'h0000000A_0000000A, 1, 1, 1));
        vecs.push_back(mk("lr2",     4'hB, 0, 'h20, 64'h0,   'hFF, 2, 64'h11111111_11111111, 1, 0, 1));
        vecs.push_back(mk("sc2_ok",  4'hC, 0, 'h20, 64'hAB,  'hFF, 2, 64'h0, 1, 0, 1));
        vecs.push_back(mk("ld_20",   4'h0, 0, 'h20, 64'h0,   'hFF, 6, 64'hAB, 1, 0, 1));
        vecs.push_back(mk("sc2_fail",4'hC, 0, 'h20, 64'hCD,  'hFF, 2, 64'h1, 1, 0, 0));
        vecs.push_back(mk("lr1",     4'hB, 0, 'h30, 64'h0,   'hFF, 1, 64'h0, 1, 0, 1));
        vecs.push_back(mk("lr3",     4'hB, 0, 'h30, 64'h0,   'hFF, 3, 64'h0, 1, 0, 1));
        vecs.push_back(mk("st_30b",  4'h0, 1, 'h30, 64'h55,  'hFF, 0, 64'h0, 0, 0, 1));
        vecs.push_back(mk("sc1",     4'hC, 0, 'h30, 64'h66,  'hFF, 1, 64'h1, 1, 0, 0));
        vecs.push_back(mk("sc3",     4'hC, 0, 'h30, 64'h77,  'hFF, 3, 64'h1, 1, 0, 0));
        vecs.push_back(mk("lr1b",    4'hB, 0, 'h30, 64'h0,   'hFF, 1, 64'h55, 1, 0, 1));
        vecs.push_back(mk("sc1_34",  4'hC, 0, 'h34, 64'h88,  'hFF, 1, 64'h1, 1, 0, 0));

        rst_ni = 1'b0; in_req_i = 1'b0; in_amo_i = '0; in_wen_i = 1'b0;
        in_add_i = '0; in_wdata_i = '0; in_be_i = '0; in_id_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset/rvalid", 64'(in_rvalid_o), 64'd0);
        check("reset/rid", 64'(in_rid_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        foreach (vecs[i]) begin
            model(vecs[i], e);  // keeps the reference state in step
            run_vec(vecs[i]);
        end

        // Reset during AmoWrite: write-back dropped, reservations forgotten.
        run_model(mk("st_3a", 4'h0, 1, 'h3A, 64'h1234, 'hFF, 0, 0, 0, 0, 1));
        run_model(mk("lr4",   4'hB, 0, 'h38, 64'h0,    'hFF, 4, 0, 0, 0, 1));
        run_model(mk("lr5",   4'hB, 0, 'h3A, 64'h0,    'hFF, 5, 0, 0, 0, 1));
        v = mk("swap_rst", 4'h1, 0, 'h3A, 64'h77, 'h0F, 6, 64'h1234, 1, 0, 1);
        issue(v, rd, rid, rv, st, breq);
        check("swap_rst/rdata", rd, 64'h1234);
        check("swap_rst/rvalid", 64'(rv), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("rst_mid/rvalid", 64'(in_rvalid_o), 64'd0);
        check("rst_mid/rid", 64'(in_rid_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int m = 0; m < 8; m++) rsv_valid[m] = 1'b0;
        last_amo = 1'b0;
        check("rst_mid/no_writeback", bank_mem[8'h3A], 64'h1234);
        run_vec(mk("sc4_after_rst", 4'hC, 0, 'h38, 64'h99, 'hFF, 4, 64'h1, 1, 0, 0));
        run_vec(mk("sc5_after_rst", 4'hC, 0, 'h3A, 64'h99, 'hFF, 5, 64'h1, 1, 0, 0));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4; i++)
            run_model(mk($sformatf("pre_%0d", i), 4'h0, 1, 32'h20 + 32'(i),
                         {$urandom, $urandom}, 'hFF, 3'($urandom_range(0, 7)), 0, 0, 0, 1));
        for (int n = 0; n < 400; n++) begin
            int          kind;
            logic [31:0] addr;
            logic [3:0]  amo;
            logic [7:0]  be;
            logic [63:0] wd;
            kind = $urandom_range(0, 9);
            addr = 32'h20 + 32'($urandom_range(0, 3));
            wd   = {$urandom, $urandom};
            be   = 8'hFF;
            if (kind <= 1)      amo = 4'h0;
            else if (kind == 2) begin amo = 4'h0; be = 8'($urandom_range(1, 255)); end
            else if (kind <= 4) amo = 4'hB;
            else if (kind <= 6) begin amo = 4'hC; be = 8'($urandom_range(1, 255)); end
            else begin
                amo = 4'($urandom_range(1, 10));
                be  = $urandom_range(0, 1) ? 8'hF0 : 8'h0F;
                if (amo == 4'hA && $urandom_range(0, 1) == 1)
                    wd[31:0] = be[4] ? ref_mem[addr[7:0]][63:32] : ref_mem[addr[7:0]][31:0];
            end
            v = mk($sformatf("rnd%0d", n), amo, (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1)) & (amo != 4'h0),
                   addr, wd, be, 3'($urandom_range(0, 7)), 0, 0, 0, 1);
            run_model(v);
        end

        @(negedge clk_i);
        for (int i = 0; i < 256; i++)
            if (ref_written[i]) check($sformatf("mem_%0h", i), bank_mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/amo_lrsc_shim.md
Name: amo_lrsc_shim

Overview:
- Next-generation atomic shim placed in front of a single-port SRAM bank with 1-cycle read latency; the shim has exclusive access to the bank.
- Adds per-master LR/SC reservations, response valid/ID tagging and parametrised master count over the existing AMO set.
- Executes AMOs as a read-modify-write and stalls new requests for exactly one cycle during write-back.

Parameters:
AddrMemWidth, 32, word address width into the bank
DataWidth, 64, bank data width; only 32 or 64 legal (elaboration fatal otherwise)
NumMasters, 8, number of requesters; one reservation slot per master
IdWidth, $clog2(NumMasters) (min 1), master ID width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_req_i  in  1  request
in_gnt_o  out  1  grant
in_add_i  in  AddrMemWidth  word address
in_amo_i  in  4  op: 0 None, 1 Swap, 2 Add, 3 And, 4 Or, 5 Xor, 6 Max, 7 Maxu, 8 Min, 9 Minu, A CAS, B LR, C SC
in_wen_i  in  1  1 store, 0 load (ignored when in_amo_i != 0)
in_wdata_i  in  DataWidth  write data / AMO operand
in_be_i  in  DataWidth/8  byte enable
in_id_i  in  IdWidth  master ID
in_rdata_o  out  DataWidth  response data
in_rvalid_o  out  1  response valid
in_rid_o  out  IdWidth  response ID
out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o  out  1/AddrMemWidth/1/DataWidth/DataWidth/8  bank request side
out_rdata_i  in  DataWidth  bank read data, valid 1 cycle after a read

Behaviour:
- Reset: state Idle, all reservations invalid, in_rvalid_o=0, in_rid_o=0. Reset asserted mid-AMO aborts the operation; no write-back occurs after reset release.
- Idle, plain access: full combinational feed-through; in_gnt_o=in_req_i.
- Every granted request produces in_rvalid_o=1 exactly one cycle later, with in_rid_o set to the registered in_id_i. in_rdata_o=out_rdata_i for loads and stores.
- Operand word: DataWidth=64 uses the upper word when in_be_i[4]=1, else the lower word. DataWidth=32 uses the whole word.
- AMO (codes 1-A), granted in Idle:
  - Grant cycle: issue read (out_wen_o=0). Latch op, addr, id, upper-word flag, operand b, CAS swap value. Go to AmoWrite.
  - AmoWrite: in_gnt_o=0. Drive out_req_o=1, out_wen_o=1, out_add_o=addr_q. out_be_o = 0xF0 (upper) or 0x0F (lower); 0xF for 32-bit. Write the result into the selected word.
  - AmoWrite response: in_rvalid_o=1, in_rdata_o = old word placed in the selected half, other half 0. Next state Idle.
- ALU (32-bit):
  - Swap -> b. Add -> a+b mod 2^32. And/Or/Xor are bitwise.
  - Max/Min use signed compare; Maxu/Minu use unsigned compare; a 33-bit subtract a-b is used for all compares.
  - CAS (DataWidth=64 only): compare value = in_wdata_i[31:0], new value = in_wdata_i[63:32]. Result = new value if old==compare, else old (write still issued). CAS with DataWidth=32 writes old value back and raises a simulation error.
- LR (B): plain read. Sets reservation[in_id_i] = {valid, in_add_i}, overwriting any previous reservation for that ID. No stall.
- SC (C):
  - Success when reservation[in_id_i] is valid and its addr == in_add_i. On success: write issued (out_wen_o=1, in_be_i/in_wdata_i pass through); response data 0.
  - Failure: out_req_o=0 (no bank access); response data 1.
  - SC always invalidates reservation[in_id_i].
  - No stall.
- Invalidation: any bank write (store, AMO write-back, successful SC) clears every valid reservation whose addr matches the written address, including other masters' reservations. An LR and an invalidating write in the same cycle cannot occur (single port).
- Back-to-back: a new request is accepted in the cycle after AmoWrite. Requests held during AmoWrite stay pending (in_req_i must remain stable).

Test Plan:
- 64b, mem[0x10]=0x00000005_00000007; AMOAdd be=0x0F wdata[31:0]=3 -> rvalid rdata=0x00000000_00000007, gnt low for 1 cycle, mem=0x00000005_0000000A.
- AMOMax lower word old=0xFFFFFFFF, b=1 -> result 1. AMOMaxu same operands -> result 0xFFFFFFFF. AMOMin with old=0x80000000, b=0 -> 0x80000000.
- AMOCAS be=0x0F, old=7, wdata=0x0000_0009_0000_0007 -> mem low=9, rdata low=7. Repeat with compare=8 -> mem unchanged (low=9), rdata low=9.
- LR id2 @0x20; SC id2 @0x20 wdata=0xAB -> rdata 0, mem=0xAB. Second SC id2 @0x20 -> rdata 1, no bank request.
- LR id1 @0x30, LR id3 @0x30; store id0 @0x30 -> SC id1 and SC id3 both return 1. LR id1 @0x30 then SC id1 @0x34 -> 1.
- Assert rst_ni during AmoWrite -> no write-back, in_rvalid_o=0, reservations cleared (subsequent SC fails).
